// File: rtl/cpu_data_collector_pkg.sv
// Shared types and the round-robin search used by the CPU data collector.
package cpu_collector_pkg;
  localparam int DATA_W  = 64;
  localparam int MAX_CPU = 16;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [31:0]       cnt_t;

  // Lanes above CPU_NB are presented as zero, so wrapping over 16 slots
  // finds the same winner as wrapping modulo CPU_NB.
  function automatic logic [3:0] next_rr(input logic [3:0] ptr,
                                         input logic [MAX_CPU-1:0] req);
    logic [3:0] idx;
    logic       found;
    next_rr = ptr;
    found   = 1'b0;
    for (int i = 0; i < MAX_CPU; i++) begin
      idx = ptr + 4'(i);
      if (!found && req[idx]) begin
        next_rr = idx;
        found   = 1'b1;
      end
    end
  endfunction
endpackage

// File: rtl/cpu_data_collector_if.sv
// Lane-input and merged-output bus of the CPU data collector.
interface cpu_data_collector_if #(
  parameter int CPU_NB = 4,
  parameter int DATA_W = 64,
  parameter int IDX_W  = (CPU_NB > 1) ? $clog2(CPU_NB) : 1
);
  logic [CPU_NB-1:0]        in_vld;
  logic [CPU_NB*DATA_W-1:0] in_data;
  logic [CPU_NB-1:0]        in_rdy;
  logic                     out_vld;
  logic                     out_rdy;
  logic [DATA_W-1:0]        out_data;
  logic [IDX_W-1:0]         out_cpu_idx;
  logic [CPU_NB-1:0]        done;
  logic                     all_done;

  // master: pollers and consumer; slave: the collector
  modport master (output in_vld, in_data, out_rdy,
                  input  in_rdy, out_vld, out_data, out_cpu_idx, done, all_done);
  modport slave  (input  in_vld, in_data, out_rdy,
                  output in_rdy, out_vld, out_data, out_cpu_idx, done, all_done);
endinterface

// File: rtl/cpu_data_collector_sync_fifo.sv
// Single-clock FIFO with registered count; head word is read combinationally.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push, w_do_pop;

  // full/empty come from the pre-update count, so a full FIFO refuses a push
  // even when it is popped in the same cycle
  assign full      = (r_count == (AW+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign pop_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/cpu_data_collector.sv
// Per-CPU lane FIFOs merged round-robin into one tagged stream, with
// per-lane delivery counters and sticky done flags.
module cpu_data_collector
  import cpu_collector_pkg::*;
#(
  parameter int CPU_NB         = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int TRANSACTION_NB = 1000,
  parameter int DATA_W         = 64
) (
  input logic                  clk,
  input logic                  rst,
  cpu_data_collector_if.slave  bus
);
  localparam int IDX_W = (CPU_NB > 1) ? $clog2(CPU_NB) : 1;

  logic [CPU_NB-1:0]             w_full, w_empty, w_push, w_pop, w_req;
  logic [CPU_NB-1:0][DATA_W-1:0] w_head;
  logic [MAX_CPU-1:0]            w_req_ext;
  logic [3:0]                    w_grant4;
  logic [IDX_W-1:0]              w_grant, w_ptr_nxt;
  logic                          w_free, w_any, w_hs;

  logic                          r_out_vld;
  logic [DATA_W-1:0]             r_out_data;
  logic [IDX_W-1:0]              r_out_idx;
  logic [IDX_W-1:0]              r_rr_ptr;
  logic [CPU_NB-1:0][31:0]       r_cnt;
  logic [CPU_NB-1:0]             r_done;

  for (genvar g = 0; g < CPU_NB; g++) begin : g_lane
    sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (w_push[g]),
      .push_data (bus.in_data[g*DATA_W +: DATA_W]),
      .pop       (w_pop[g]),
      .pop_data  (w_head[g]),
      .full      (w_full[g]),
      .empty     (w_empty[g])
    );
  end

  assign bus.in_rdy = ~w_full;
  assign w_push     = bus.in_vld & ~w_full;
  assign w_req      = ~w_empty;
  assign w_any      = |w_req;
  assign w_free     = !r_out_vld || bus.out_rdy;
  assign w_hs       = r_out_vld && bus.out_rdy;

  assign w_req_ext = MAX_CPU'(w_req);
  assign w_grant4  = next_rr(4'(r_rr_ptr), w_req_ext);
  assign w_grant   = IDX_W'(w_grant4);
  assign w_ptr_nxt = (w_grant4 == 4'(CPU_NB-1)) ? '0 : IDX_W'(w_grant4 + 4'd1);
  assign w_pop     = (w_free && w_any) ? (CPU_NB'(1) << w_grant) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_out_idx  <= '0;
      r_rr_ptr   <= '0;
    end else if (w_free) begin
      r_out_vld <= w_any;
      if (w_any) begin
        r_out_data <= w_head[w_grant];
        r_out_idx  <= w_grant;
        r_rr_ptr   <= w_ptr_nxt;
      end
    end
  end

  // done follows the registered count, one cycle behind the final handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_done <= '0;
    end else begin
      for (int i = 0; i < CPU_NB; i++) begin
        if (w_hs && r_out_idx == IDX_W'(i) && r_cnt[i] != '1)
          r_cnt[i] <= r_cnt[i] + 32'd1;
        if (r_cnt[i] >= cnt_t'(TRANSACTION_NB))
          r_done[i] <= 1'b1;
      end
    end
  end

  assign bus.out_vld     = r_out_vld;
  assign bus.out_data    = r_out_data;
  assign bus.out_cpu_idx = r_out_idx;
  assign bus.done        = r_done;
  assign bus.all_done    = &r_done;
endmodule

// File: tb/tb_cpu_data_collector.sv
// Directed and randomized checks of cpu_data_collector (4 lanes, depth 8).
module tb_cpu_data_collector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  cpu_data_collector_if #(.CPU_NB(4), .DATA_W(64)) bus ();
  cpu_data_collector_if #(.CPU_NB(4), .DATA_W(64)) bus_b ();

  assign bus_b.in_vld  = bus.in_vld;
  assign bus_b.in_data = bus.in_data;
  assign bus_b.out_rdy = bus.out_rdy;

  cpu_data_collector #(.CPU_NB(4), .FIFO_DEPTH(8), .TRANSACTION_NB(3), .DATA_W(64))
    u_dut (.clk(clk), .rst(rst), .bus(bus));

  cpu_data_collector #(.CPU_NB(4), .FIFO_DEPTH(8), .TRANSACTION_NB(1000), .DATA_W(64))
    u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // push one word on a lane and return the next word to appear on the output
  task automatic send_one(input int lane, input logic [63:0] d,
                          output logic [63:0] got_d, output logic [1:0] got_i);
    bit seen = 0;
    bus.in_vld[lane] = 1'b1;
    bus.in_data[lane*64 +: 64] = d;
    tick();
    bus.in_vld[lane] = 1'b0;
    got_d = '0;
    got_i = '0;
    for (int t = 0; t < 8 && !seen; t++) begin
      if (bus.out_vld) seen = 1;
      else tick();
    end
    if (seen) begin
      got_d = bus.out_data;
      got_i = bus.out_cpu_idx;
    end else begin
      got_d = 64'hFFFF_FFFF_FFFF_FFFF;
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++; if (bus.out_vld !== 1'b0) begin n_bad++; $display("FAIL reset_out_vld got %0b want 0", bus.out_vld); end
    n_cmp++; if (bus.out_data !== 64'd0) begin n_bad++; $display("FAIL reset_out_data got %h want 0", bus.out_data); end
    n_cmp++; if (bus.out_cpu_idx !== 2'd0) begin n_bad++; $display("FAIL reset_idx got %0d want 0", bus.out_cpu_idx); end
    n_cmp++; if (bus.done !== 4'b0000) begin n_bad++; $display("FAIL reset_done got %b want 0000", bus.done); end
    n_cmp++; if (bus.all_done !== 1'b0) begin n_bad++; $display("FAIL reset_all_done got %0b want 0", bus.all_done); end
    n_cmp++; if (bus.in_rdy !== 4'b1111) begin n_bad++; $display("FAIL reset_in_rdy got %b want 1111", bus.in_rdy); end
  endtask

  task automatic test_single();
    bus.out_rdy = 1'b1;
    bus.in_vld[2] = 1'b1;
    bus.in_data[2*64 +: 64] = 64'hDEADBEEF_00000001;
    tick();
    bus.in_vld[2] = 1'b0;
    n_cmp++; if (bus.out_vld !== 1'b0) begin n_bad++; $display("FAIL single_early got vld %0b want 0", bus.out_vld); end
    tick();
    n_cmp++;
    if (bus.out_vld !== 1'b1 || bus.out_data !== 64'hDEADBEEF_00000001 || bus.out_cpu_idx !== 2'd2) begin
      n_bad++;
      $display("FAIL single_word got vld=%0b data=%h idx=%0d want 1 deadbeef00000001 2",
               bus.out_vld, bus.out_data, bus.out_cpu_idx);
    end
    tick();
    n_cmp++; if (bus.out_vld !== 1'b0) begin n_bad++; $display("FAIL single_one_cycle got vld %0b want 0", bus.out_vld); end
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.out_rdy = 1'b1;
    bus.in_vld = 4'b1111;
    for (int i = 0; i < 4; i++) bus.in_data[i*64 +: 64] = 64'h1000 + 64'(i);
    tick();
    bus.in_vld = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (bus.out_vld !== 1'b1 || bus.out_cpu_idx !== 2'(i) || bus.out_data !== 64'h1000 + 64'(i)) begin
        n_bad++;
        $display("FAIL rr_order slot %0d got vld=%0b idx=%0d data=%h want 1 %0d %h",
                 i, bus.out_vld, bus.out_cpu_idx, bus.out_data, i, 64'h1000 + 64'(i));
      end
    end
    tick();
    n_cmp++; if (bus.out_vld !== 1'b0) begin n_bad++; $display("FAIL rr_drained got vld %0b want 0", bus.out_vld); end
    // lane 1 alone moves the pointer to 2, so lane 3 must beat lane 0
    bus.in_vld = 4'b0010;
    bus.in_data[1*64 +: 64] = 64'h2001;
    tick();
    bus.in_vld = 4'b0000;
    tick();
    n_cmp++; if (bus.out_cpu_idx !== 2'd1 || bus.out_data !== 64'h2001) begin n_bad++; $display("FAIL rr_lane1 got idx=%0d data=%h want 1 2001", bus.out_cpu_idx, bus.out_data); end
    tick();
    bus.in_vld = 4'b1001;
    bus.in_data[0*64 +: 64] = 64'h3000;
    bus.in_data[3*64 +: 64] = 64'h3003;
    tick();
    bus.in_vld = 4'b0000;
    tick();
    n_cmp++; if (bus.out_vld !== 1'b1 || bus.out_cpu_idx !== 2'd3 || bus.out_data !== 64'h3003) begin n_bad++; $display("FAIL rr_ptr_first got idx=%0d data=%h want 3 3003", bus.out_cpu_idx, bus.out_data); end
    tick();
    n_cmp++; if (bus.out_vld !== 1'b1 || bus.out_cpu_idx !== 2'd0 || bus.out_data !== 64'h3000) begin n_bad++; $display("FAIL rr_ptr_wrap got idx=%0d data=%h want 0 3000", bus.out_cpu_idx, bus.out_data); end
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.out_rdy = 1'b0;
    for (int k = 0; k < 9; k++) begin
      bus.in_vld[0] = 1'b1;
      bus.in_data[0 +: 64] = 64'hA0 + 64'(k);
      n_cmp++; if (bus.in_rdy[0] !== 1'b1) begin n_bad++; $display("FAIL bp_in_rdy word %0d got 0 want 1", k); end
      tick();
      if (k >= 1) begin
        n_cmp++;
        if (bus.out_vld !== 1'b1 || bus.out_data !== 64'hA0) begin
          n_bad++; $display("FAIL bp_stall word %0d got vld=%0b data=%h want 1 a0", k, bus.out_vld, bus.out_data);
        end
      end
    end
    n_cmp++; if (bus.in_rdy[0] !== 1'b0) begin n_bad++; $display("FAIL bp_full got in_rdy %0b want 0", bus.in_rdy[0]); end
    bus.in_data[0 +: 64] = 64'hBAD;
    tick();
    tick();
    bus.in_vld[0] = 1'b0;
    n_cmp++; if (bus.out_data !== 64'hA0) begin n_bad++; $display("FAIL bp_hold got %h want a0", bus.out_data); end
    bus.out_rdy = 1'b1;
    for (int j = 0; j < 9; j++) begin
      n_cmp++;
      if (bus.out_vld !== 1'b1 || bus.out_data !== 64'hA0 + 64'(j)) begin
        n_bad++; $display("FAIL bp_drain word %0d got vld=%0b data=%h want 1 %h", j, bus.out_vld, bus.out_data, 64'hA0 + 64'(j));
      end
      tick();
    end
    n_cmp++; if (bus.out_vld !== 1'b0) begin n_bad++; $display("FAIL bp_no_extra got vld %0b want 0", bus.out_vld); end
  endtask

  task automatic test_done();
    logic [63:0] gd;
    logic [1:0]  gi;
    do_reset();
    bus.out_rdy = 1'b1;
    send_one(1, 64'h4100, gd, gi);
    send_one(1, 64'h4101, gd, gi);
    tick();
    n_cmp++; if (bus.done !== 4'b0000) begin n_bad++; $display("FAIL done_early got %b want 0000", bus.done); end
    send_one(1, 64'h4102, gd, gi);
    n_cmp++; if (gd !== 64'h4102 || gi !== 2'd1) begin n_bad++; $display("FAIL done_word3 got %h idx %0d want 4102 1", gd, gi); end
    tick();
    n_cmp++; if (bus.done !== 4'b0010) begin n_bad++; $display("FAIL done_lane1 got %b want 0010", bus.done); end
    n_cmp++; if (bus.all_done !== 1'b0) begin n_bad++; $display("FAIL done_all_early got %0b want 0", bus.all_done); end
    send_one(1, 64'h4103, gd, gi);
    n_cmp++; if (gd !== 64'h4103) begin n_bad++; $display("FAIL done_passthru got %h want 4103", gd); end
    tick();
    n_cmp++; if (bus.done !== 4'b0010) begin n_bad++; $display("FAIL done_sticky got %b want 0010", bus.done); end
    for (int l = 0; l < 4; l++) begin
      if (l == 1) continue;
      for (int w = 0; w < 3; w++) begin
        if (l == 3 && w == 2) begin
          tick();
          n_cmp++; if (bus.all_done !== 1'b0) begin n_bad++; $display("FAIL done_all_pre got %0b want 0", bus.all_done); end
        end
        send_one(l, 64'h4000 + 64'(l*16 + w), gd, gi);
      end
    end
    tick();
    n_cmp++; if (bus.all_done !== 1'b1 || bus.done !== 4'b1111) begin n_bad++; $display("FAIL done_all got all=%0b done=%b want 1 1111", bus.all_done, bus.done); end
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    n_cmp++; if (bus.done !== 4'b1111) begin n_bad++; $display("FAIL mid_pre_done got %b want 1111", bus.done); end
    bus.out_rdy = 1'b0;
    bus.in_vld = 4'b1111;
    for (int i = 0; i < 4; i++) bus.in_data[i*64 +: 64] = 64'h5000 + 64'(i);
    tick();
    bus.in_vld = 4'b0001;
    bus.in_data[0 +: 64] = 64'h5100;
    tick();
    bus.in_vld = 4'b0000;
    n_cmp++; if (bus.out_vld !== 1'b1 || bus.out_data !== 64'h5000) begin n_bad++; $display("FAIL mid_loaded got vld=%0b data=%h want 1 5000", bus.out_vld, bus.out_data); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (bus.out_vld !== 1'b0) begin n_bad++; $display("FAIL mid_vld got %0b want 0", bus.out_vld); end
    n_cmp++; if (bus.done !== 4'b0000) begin n_bad++; $display("FAIL mid_done got %b want 0000", bus.done); end
    n_cmp++; if (bus.in_rdy !== 4'b1111) begin n_bad++; $display("FAIL mid_in_rdy got %b want 1111", bus.in_rdy); end
    bus.out_rdy = 1'b1;
    for (int t = 0; t < 12; t++) begin
      if (bus.out_vld) stale++;
      tick();
    end
    n_cmp++; if (stale != 0) begin n_bad++; $display("FAIL mid_stale got %0d words want 0", stale); end
  endtask

  task automatic test_random();
    int          sent [4];
    int          rcv  [4];
    int          cyc = 0;
    logic [1:0]  idx;
    logic [63:0] exp_d;
    do_reset();
    for (int i = 0; i < 4; i++) begin sent[i] = 0; rcv[i] = 0; end
    while ((rcv[0] < 1000 || rcv[1] < 1000 || rcv[2] < 1000 || rcv[3] < 1000) && cyc < 40000) begin
      for (int i = 0; i < 4; i++) begin
        bus.in_vld[i] = (sent[i] < 1000) && ($urandom_range(0, 3) != 0);
        bus.in_data[i*64 +: 64] = {16'hC0DE, 16'(i), 32'(sent[i])};
      end
      bus.out_rdy = ($urandom_range(0, 3) != 0);
      if (bus.out_vld && bus.out_rdy) begin
        idx = bus.out_cpu_idx;
        exp_d = {16'hC0DE, 16'(idx), 32'(rcv[idx])};
        n_cmp++;
        if (bus.out_data !== exp_d) begin
          n_bad++; $display("FAIL rand_order lane %0d got %h want %h", idx, bus.out_data, exp_d);
        end
        rcv[idx]++;
      end
      for (int i = 0; i < 4; i++) if (bus.in_vld[i] && bus.in_rdy[i]) sent[i]++;
      tick();
      cyc++;
    end
    bus.in_vld = 4'b0000;
    bus.out_rdy = 1'b1;
    n_cmp++;
    if (rcv[0] != 1000 || rcv[1] != 1000 || rcv[2] != 1000 || rcv[3] != 1000) begin
      n_bad++; $display("FAIL rand_budget got %0d %0d %0d %0d want 1000 each", rcv[0], rcv[1], rcv[2], rcv[3]);
    end
    tick();
    tick();
    n_cmp++; if (bus.out_vld !== 1'b0) begin n_bad++; $display("FAIL rand_extra got vld %0b want 0", bus.out_vld); end
    n_cmp++; if (bus_b.all_done !== 1'b1) begin n_bad++; $display("FAIL rand_all_done got %0b want 1", bus_b.all_done); end
  endtask

  initial begin
    bus.in_vld  = '0;
    bus.in_data = '0;
    bus.out_rdy = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_done();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before end of tests");
    $fatal(1);
  end
endmodule
